// File: rtl/count6_mon.sv
// count6_mon: tracks a 6-bit modulo-64 up-counter with load, predicting its
// next value each cycle and flagging deviations. Three consecutive
// mismatches drop the lock and force a fresh acquisition.
module count6_mon (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [5:0] cnt_in,
   input  logic       load,
   input  logic [5:0] data,
   output logic       locked,
   output logic       err,
   output logic       wrap,
   output logic [5:0] expected,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACQ   = 2'd1,
      TRACK = 2'd2
   } state_t;

   state_t     state, state_n;
   logic [1:0] miss, miss_n;
   logic [5:0] expected_n;
   logic [7:0] err_cnt_n;
   logic       err_n, wrap_n;
   logic [5:0] pred;

   // locked decodes the registered state, so it has no input-to-output path
   assign locked = (state == TRACK);

   // state and registered outputs; rst overrides every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         miss     <= '0;
         expected <= '0;
         err_cnt  <= '0;
         err      <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         state    <= state_n;
         miss     <= miss_n;
         expected <= expected_n;
         err_cnt  <= err_cnt_n;
         err      <= err_n;
         wrap     <= wrap_n;
      end
   end

   // next-state, prediction, compare and pulse generation
   always_comb begin
      pred       = load ? data : cnt_in + 6'd1;
      state_n    = state;
      miss_n     = miss;
      expected_n = expected;
      err_cnt_n  = err_cnt;
      err_n      = 1'b0;
      wrap_n     = 1'b0;
      if (!en) begin
         state_n = IDLE;
         miss_n  = '0;
      end else begin
         case (state)
            IDLE: state_n = ACQ;
            ACQ: begin
               expected_n = pred;
               state_n    = TRACK;
            end
            TRACK: begin
               // prediction always resyncs to the observed sample
               expected_n = pred;
               if (cnt_in == expected) begin
                  miss_n = '0;
                  wrap_n = (cnt_in == 6'd63) && !load;
               end else begin
                  err_n = 1'b1;
                  if (err_cnt != 8'hFF)
                     err_cnt_n = err_cnt + 8'd1;
                  if (miss == 2'd2) begin
                     state_n = ACQ;
                     miss_n  = '0;
                  end else begin
                     miss_n = miss + 2'd1;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule
